// File: rtl/dmem_arbiter.sv
// Arbitrates the shared D_memory port between the MEM stage and an external requester.
// The CPU has priority; a starvation counter forces a one-cycle external slot.
module dmem_arbiter #(
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 16,
  parameter int unsigned STARVE = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic [DW-1:0] ext_rdata,
  output logic          ext_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   stall_cnt
);

  typedef enum logic [0:0] {StPri, StForce} state_e;

  localparam logic [3:0] WaitMax = 4'(STARVE - 1);

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        ext_rvalid_q;
  logic [15:0] stall_cnt_q;
  logic        cpu_gnt;

  always_comb begin
    state_d    = StPri;
    wait_cnt_d = wait_cnt_q;
    cpu_gnt    = 1'b0;
    ext_gnt    = 1'b0;
    cpu_stall  = 1'b0;
    unique case (state_q)
      StPri: begin
        if (cpu_req) begin
          cpu_gnt = 1'b1;
        end else if (ext_req) begin
          ext_gnt = 1'b1;
        end
        if (ext_gnt) begin
          wait_cnt_d = '0;
        end else if (ext_req) begin
          // STARVE consecutive denials buy the external side the next cycle
          if (wait_cnt_q == WaitMax) begin
            state_d    = StForce;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end
      end
      StForce: begin
        wait_cnt_d = '0;
        if (ext_req) begin
          ext_gnt   = 1'b1;
          cpu_stall = cpu_req;
        end else begin
          cpu_gnt = cpu_req;
        end
      end
      default: ;
    endcase
    // Reset suppresses every grant so an aborted forced write never reaches memory
    if (rst) begin
      cpu_gnt   = 1'b0;
      ext_gnt   = 1'b0;
      cpu_stall = 1'b0;
    end
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = cpu_gnt & cpu_we;
    if (ext_gnt) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_we    = ext_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StPri;
      wait_cnt_q   <= '0;
      ext_rvalid_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      ext_rvalid_q <= ext_gnt & ~ext_we;
      if (cpu_stall && stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign ext_rdata  = mem_rdata;
  assign ext_rvalid = ext_rvalid_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a registered-read memory model and
// a scoreboard of expected load data keyed by the cycle it should appear.
module tb_dmem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          ext_req, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt;
  logic [DW-1:0] ext_rdata;
  logic          ext_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic [15:0]   stall_cnt;

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE(3)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // D_memory stand-in: synchronous write, registered read
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[7:0]];
  end

  typedef struct {
    int          cyc;
    bit          ext;
    logic [15:0] data;
  } sb_entry_t;

  sb_entry_t sb[$];
  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input bit ext, input logic [15:0] data);
    sb_entry_t e;
    e.cyc  = cyc + 1;
    e.ext  = ext;
    e.data = data;
    sb.push_back(e);
  endtask

  // Called on the falling edge: retire due entries and check ext_rvalid alignment
  task automatic sb_check();
    sb_entry_t e;
    bit ext_due = 1'b0;
    while (sb.size() != 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      if (e.ext) begin
        ext_due = 1'b1;
        check("ext_rdata", ext_rdata, e.data);
      end else begin
        check("cpu_rdata", cpu_rdata, e.data);
      end
    end
    check("ext_rvalid", ext_rvalid, ext_due);
  endtask

  task automatic drive(input bit cr, input bit cw, input logic [15:0] ca, input logic [15:0] cd,
                       input bit er, input bit ew, input logic [15:0] ea, input logic [15:0] ed);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
  endtask

  task automatic sample(input bit use_sb);
    @(negedge clk);
    if (use_sb) sb_check();
  endtask

  task automatic adv();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    ram[8'h20] = 16'hBEEF;
    ram[8'h30] = 16'hCAFE;
    ram[8'h40] = 16'h5A5A;

    // Reset with both sides requesting a store
    rst = 1'b1;
    drive(1, 1, 16'h0010, 16'h1111, 1, 1, 16'h0030, 16'h2222);
    sample(0);
    check("rst_ext_gnt", ext_gnt, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_cpu_stall", cpu_stall, 0);
    adv();
    sample(0);
    check("rst_ext_gnt2", ext_gnt, 0);
    check("rst_mem_we2", mem_we, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_ext_rvalid", ext_rvalid, 0);
    adv();
    rst = 1'b0;

    // First cycle after release: CPU load of 0x0020 is granted
    drive(1, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    push(0, 16'hBEEF);
    sample(1);
    check("rel_cpu_stall", cpu_stall, 0);
    check("rel_ext_gnt", ext_gnt, 0);
    check("rel_mem_addr", mem_addr, 16'h0020);
    adv();

    // CPU store then load
    drive(1, 1, 16'h0010, 16'h1234, 0, 0, 16'h0000, 16'h0000);
    sample(1);
    check("st_mem_we", mem_we, 1);
    check("st_mem_addr", mem_addr, 16'h0010);
    check("st_mem_wdata", mem_wdata, 16'h1234);
    check("st_cpu_stall", cpu_stall, 0);
    adv();
    drive(1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    push(0, 16'h1234);
    sample(1);
    check("ld_mem_we", mem_we, 0);
    check("ld_cpu_stall", cpu_stall, 0);
    adv();

    // External load in an idle gap
    drive(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0020, 16'h0000);
    push(1, 16'hBEEF);
    sample(1);
    check("gap_ext_gnt", ext_gnt, 1);
    check("gap_mem_addr", mem_addr, 16'h0020);
    adv();
    drive(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    sample(1);
    check("idle_ext_gnt", ext_gnt, 0);
    check("idle_mem_we", mem_we, 0);
    adv();

    // Starvation: continuous CPU loads vs continuous external loads
    drive(1, 0, 16'h0010, 16'h0000, 1, 0, 16'h0040, 16'h0000);
    for (int k = 0; k < 12; k++) begin
      bit f;
      f = (k % 4) == 3;
      if (f) push(1, 16'h5A5A);
      else   push(0, 16'h1234);
      sample(1);
      check("sv_ext_gnt", ext_gnt, f);
      check("sv_cpu_stall", cpu_stall, f);
      check("sv_mem_addr", mem_addr, f ? 16'h0040 : 16'h0010);
      check("sv_stall_cnt", stall_cnt, k / 4);
      adv();
    end

    // Three more denials, then drop ext_req in the FORCE cycle
    for (int k = 0; k < 4; k++) begin
      if (k == 3) ext_req = 1'b0;
      push(0, 16'h1234);
      sample(1);
      check("drop_ext_gnt", ext_gnt, 0);
      check("drop_cpu_stall", cpu_stall, 0);
      adv();
    end
    check("drop_stall_cnt", stall_cnt, 3);

    // Wait count restarts from zero: three denials, then reset lands on the FORCE cycle
    drive(1, 0, 16'h0010, 16'h0000, 1, 1, 16'h0030, 16'hDEAD);
    for (int k = 0; k < 3; k++) begin
      push(0, 16'h1234);
      sample(1);
      check("pre_ext_gnt", ext_gnt, 0);
      adv();
    end
    rst = 1'b1;
    sample(1);
    check("rf_mem_we", mem_we, 0);
    check("rf_ext_gnt", ext_gnt, 0);
    check("rf_cpu_stall", cpu_stall, 0);
    adv();
    rst = 1'b0;

    // Target of the aborted write must still hold its old value
    drive(1, 0, 16'h0030, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    push(0, 16'hCAFE);
    sample(1);
    check("post_stall_cnt", stall_cnt, 0);
    check("post_cpu_stall", cpu_stall, 0);
    adv();

    // State is PRI with a cleared wait count: FORCE again after three denials
    drive(1, 0, 16'h0030, 16'h0000, 1, 0, 16'h0020, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      bit f;
      f = (k == 3);
      if (f) push(1, 16'hBEEF);
      else   push(0, 16'hCAFE);
      sample(1);
      check("pr_ext_gnt", ext_gnt, f);
      check("pr_cpu_stall", cpu_stall, f);
      adv();
    end

    drive(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    for (int k = 0; k < 2; k++) begin
      sample(1);
      adv();
    end
    check("sb_drained", sb.size(), 0);
    check("end_stall_cnt", stall_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single D_memory port between the CPU pipeline's MEM stage and an external requester (program/data loader or debug port). The CPU has priority. A starvation counter guarantees the external side a slot after a bounded wait; during that slot the pipeline is stalled. The block sits between the datapath's memory-stage signals (address, store data, write enable) and the D_memory instance, and drives a stall line back to the pipeline control.

## Interface
Parameters:
- AW, 16, address width (matches ISIZE)
- DW, 16, data width (matches DSIZE)
- STARVE, 3, consecutive denied external cycles before a forced external slot (legal 1..15)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- cpu_req  in  1  MEM stage needs the memory this cycle
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU store data
- cpu_stall  out  1  CPU request not served this cycle; pipeline must hold
- cpu_rdata  out  DW  load data, valid the cycle after a granted CPU load
- ext_req  in  1  external request; held until ext_gnt
- ext_we  in  1  external store/load select
- ext_addr  in  AW  external address
- ext_wdata  in  DW  external store data
- ext_gnt  out  1  external request served this cycle
- ext_rdata  out  DW  external load data
- ext_rvalid  out  1  ext_rdata valid; the cycle after a granted external load
- mem_addr  out  AW  to D_memory address
- mem_wdata  out  DW  to D_memory data_in
- mem_we  out  1  to D_memory write_en
- mem_rdata  in  DW  from D_memory data_out; registered read, 1-cycle latency
- stall_cnt  out  16  saturating count of cpu_stall cycles since reset

## Operation
- State machine, 2 states: PRI (CPU priority) and FORCE (external slot).
- PRI:
  - cpu_req=1: CPU granted, cpu_stall=0, ext_gnt=0.
  - cpu_req=0 and ext_req=1: external granted, ext_gnt=1.
  - wait_cnt (4-bit) increments when ext_req=1 and ext_gnt=0. It clears on any ext_gnt, and holds when ext_req=0.
  - When wait_cnt reaches STARVE-1 and the external request is denied again (STARVE consecutive denials), the next state is FORCE.
- FORCE:
  - If ext_req=1: external granted, ext_gnt=1, cpu_stall=cpu_req.
  - If ext_req has dropped: no grant, and the CPU is served normally.
  - Always returns to PRI next cycle with wait_cnt=0. FORCE lasts exactly 1 cycle.
- Mux: mem_addr/mem_wdata/mem_we come from the granted requester. With no grant: mem_we=0, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
- mem_we is never 1 without a grant.
- cpu_rdata = mem_rdata (pass-through). ext_rdata = mem_rdata.
- ext_rvalid is registered: it equals (ext_gnt & ~ext_we) of the previous cycle.
- stall_cnt increments each cycle cpu_stall=1 and saturates at 0xFFFF.
- Internal stall is registered-state-derived only. No combinational path from mem_rdata to any grant.

## Timing
- Grants, cpu_stall and the mem_* mux are combinational from the current state and requests; same-cycle response.
- Read latency is 1 cycle for both requesters. A granted load at cycle N gives data at N+1.
- Reset (rst=1 at an edge):
  - State=PRI, wait_cnt=0, ext_rvalid=0, stall_cnt=0.
  - While rst=1, ext_gnt=0, cpu_stall=0 and mem_we=0, regardless of requests.
  - Reset mid-FORCE aborts the slot; no write is issued.
- Simultaneous cpu_req and ext_req in PRI with wait_cnt<STARVE-1: CPU wins. Worst-case external wait is STARVE cycles, plus the FORCE cycle for service.
- Back-to-back FORCE is impossible. At least one PRI cycle separates forced slots, so the CPU stalls at most 1 in every STARVE+1 cycles.
- The pipeline holds the MEM-stage request unchanged while cpu_stall=1. The arbiter samples it again next cycle.

## Test plan
- Reset then idle: rst=1 for 2 cycles with cpu_req=ext_req=1 → ext_gnt=0, mem_we=0, stall_cnt=0. After release, cycle 1 grants CPU.
- CPU-only store/load: store 0x1234 to 0x0010, then load 0x0010 → mem_we=1 in store cycle; cpu_rdata=0x1234 one cycle after load grant; cpu_stall never 1.
- External in idle gap: cpu_req=0, ext load 0x0020 (preloaded 0xBEEF) → ext_gnt same cycle, ext_rvalid=1 with ext_rdata=0xBEEF next cycle, wait_cnt stays 0.
- Starvation, STARVE=3: cpu_req=1 continuous, ext_req=1 from cycle 0:
  - ext denied cycles 0–2, FORCE at cycle 3: ext_gnt=1, cpu_stall=1, stall_cnt=1.
  - Cycle 4 is CPU again.
  - Pattern repeats every 4 cycles.
- Request drop in FORCE: ext_req deasserted in the FORCE cycle → no ext_gnt, cpu_stall=0, state PRI next cycle, wait_cnt=0.
- Reset mid-FORCE: rst=1 during FORCE with ext_we=1 → mem_we=0, no write reaches memory (readback of target unchanged), state PRI after reset.
